phy_reg_state: RTL and testbench
================================

Name: phy_reg_state

Overview:
- State holder for the rename stage. It owns the speculative rename map, the committed (architectural) map, the physical-copy allocation bitmap and the write-back bitmap.
- Upstream of the combinational renamer: supplies `rnAct_X_qout`/`rnBufU_qout` to it and registers its `rnAct_X_dnxt`/`rnBufU_rename_set`.
- Downstream inputs: write-back from the execute units, commit/flush from the commit stage.
- Frees physical copies on commit and restores the speculative state to the architectural state on flush.

Parameters:
- RB, 2, index bits per architectural register (copy index width).
- RP, 4, physical copies per architectural register; must equal 2**RB.

Ports:
- CLK  input  1  clock, rising edge
- RSTn  input  1  asynchronous active-low reset
- rnAct_X_dnxt  input  RB*32  next speculative map from renamer
- rnAct_X_qout  output  RB*32  speculative map; field i = current copy of x[i]
- rnBufU_rename_set  input  32*RP  one-hot allocate mask from renamer
- rnBufU_qout  output  32*RP  allocated bitmap; bit RP*i+k = copy k of x[i] in use
- wbLog_writeb_set  input  32*RP  write-back set mask (OR of all execute ports)
- wbLog_qout  output  32*RP  copy holds valid result
- archi_X_qout  output  RB*32  committed map
- commit_vaild  input  1  one instruction retires this cycle
- commit_rd  input  5+RB  renamed destination {rd, index} of retiring instruction
- commit_abort  input  1  flush: discard all speculative state

Behaviour:
- All state updates on CLK rising edge; all outputs are direct register outputs (zero combinational paths in to out).
- Reset (RSTn=0, asynchronous):
  - `rnAct_X_qout` = 0 and `archi_X_qout` = 0 (every field = copy 0).
  - `rnBufU_qout` and `wbLog_qout` = only bit RP*i+0 set for each i (i.e. 0x1 per RP-bit field, value 0x11111111_11111111_11111111_11111111 for RP=4).
- Commit (`commit_vaild`=1, `commit_abort`=0), with r = `commit_rd[5+RB-1:RB]`, k = `commit_rd[RB-1:0]`, old = `archi_X[r]` before update:
  - `archi_X[r]` <= k.
  - If old != k: clear `rnBufU[RP*r+old]` and `wbLog[RP*r+old]` (free the previously committed copy).
  - If old == k: nothing freed.
- Normal cycle (`commit_abort`=0):
  - `rnAct_X` <= `rnAct_X_dnxt`.
  - `rnBufU` <= (`rnBufU` & ~free) | `rnBufU_rename_set`.
  - `wbLog` <= ((`wbLog` & ~free & ~`rnBufU_rename_set`) | `wbLog_writeb_set`). A reallocated copy starts un-written. Write-back to the same bit in the same cycle as its allocation wins (set).
- Flush (`commit_abort`=1) overrides everything in the same cycle:
  - `commit_vaild`, `rnBufU_rename_set` and `wbLog_writeb_set` are ignored; the retiring instruction does not commit.
  - `rnAct_X` <= `archi_X` (current value).
  - `rnBufU` <= one-hot decode of `archi_X`, exactly one bit per field.
  - `wbLog` <= the same decode: committed copies are by definition written.
  - `archi_X` unchanged.
- Simultaneous free and allocate of the same bit is illegal: the renamer only allocates clear bits and the freed bit is set at that time. Implementation gives set priority; the bench asserts it never occurs.
- Commit of an index whose `rnBufU` bit is clear is illegal; bench assertion.
- Invariants checked every cycle (bench):
  - for each i, `rnBufU[RP*i+archi_X[i]]`=1 and `rnBufU[RP*i+rnAct_X[i]]`=1;
  - `wbLog` ⊆ `rnBufU`.
- x0 is handled like any other register; no special casing.
- Single commit per cycle; no back-pressure signals; block never stalls.

Test Plan:
- Reset release → `rnAct_X_qout`=0, `archi_X_qout`=0, `rnBufU_qout`=`wbLog_qout`=0x1 per field.
- Rename x5 to copy 1 (`rnAct_X_dnxt` field5=1, set bit 21), next cycle write-back bit 21, then commit_rd={5,1}:
  - after rename: field5 of `rnBufU`=0x3, `wbLog` bit21=0;
  - after write-back: bit21=1;
  - after commit: `archi_X[5]`=1, bits 20 cleared in `rnBufU` and `wbLog` (field5=0x2).
- Allocate x7 copies 1,2,3 on successive cycles, then `commit_abort` → `rnAct_X[7]`=0, field7 of `rnBufU`=0x1, `wbLog` field7=0x1.
- Same cycle: `commit_vaild` with {3,2} plus `commit_abort` → `archi_X[3]` unchanged, state equals flush of pre-cycle `archi_X`.
- Same cycle: commit {4,1} freeing copy 0, rename of x4 to copy 2, write-back of x9 copy 1 → field4 of `rnBufU`=0x6, `wbLog` field4=0x0 (or 0x2 if copy 1 was written), bit 37 set.
- Assert RSTn low asynchronously mid-sequence (between edges) → all outputs at reset values immediately, before the next CLK edge.

Source files
------------

// File: rtl/phy_reg_state.sv
// Rename-stage state: speculative and committed rename maps, per-register
// physical-copy allocation bitmap and write-back bitmap.
module phy_reg_state #(
    parameter int RB = 2,
    parameter int RP = 4   // must equal 2**RB: bit RP*i+k is addressed as {i, k}
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [RB*32-1:0]    rnAct_X_dnxt,
    output logic [RB*32-1:0]    rnAct_X_qout,
    input  logic [32*RP-1:0]    rnBufU_rename_set,
    output logic [32*RP-1:0]    rnBufU_qout,
    input  logic [32*RP-1:0]    wbLog_writeb_set,
    output logic [32*RP-1:0]    wbLog_qout,
    output logic [RB*32-1:0]    archi_X_qout,
    input  logic                commit_vaild,
    input  logic [5+RB-1:0]     commit_rd,
    input  logic                commit_abort
);

    localparam int NB = 32 * RP;

    function automatic logic [NB-1:0] copy0_bits();
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m[RP*i] = 1'b1;
        return m;
    endfunction

    localparam logic [NB-1:0] RESET_BITS = copy0_bits();

    logic [RB*32-1:0] rn_act_q, rn_act_d;
    logic [RB*32-1:0] archi_x_q, archi_x_d;
    logic [NB-1:0]    rn_buf_q, rn_buf_d;
    logic [NB-1:0]    wb_log_q, wb_log_d;

    logic [4:0]       commit_r;
    logic [RB-1:0]    commit_k;
    logic [RB-1:0]    commit_old;
    logic [NB-1:0]    free_mask;
    logic [NB-1:0]    flush_bits;

    always_comb begin
        commit_r   = commit_rd[5+RB-1:RB];
        commit_k   = commit_rd[RB-1:0];
        commit_old = archi_x_q[RB*int'(commit_r) +: RB];

        // One-hot decode of the committed map: the state a flush restores.
        flush_bits = '0;
        for (int i = 0; i < 32; i++) begin
            flush_bits[RP*i + int'(archi_x_q[RB*i +: RB])] = 1'b1;
        end

        free_mask = '0;
        archi_x_d = archi_x_q;
        rn_act_d  = rnAct_X_dnxt;
        rn_buf_d  = rn_buf_q;
        wb_log_d  = wb_log_q;

        if (commit_abort) begin
            rn_act_d = archi_x_q;
            rn_buf_d = flush_bits;
            wb_log_d = flush_bits;
        end else begin
            if (commit_vaild) begin
                archi_x_d[RB*int'(commit_r) +: RB] = commit_k;
                if (commit_old != commit_k) free_mask[{commit_r, commit_old}] = 1'b1;
            end
            rn_buf_d = (rn_buf_q & ~free_mask) | rnBufU_rename_set;
            // A reallocated copy starts unwritten unless written back this same cycle.
            wb_log_d = (wb_log_q & ~free_mask & ~rnBufU_rename_set) | wbLog_writeb_set;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rn_act_q  <= '0;
            archi_x_q <= '0;
            rn_buf_q  <= RESET_BITS;
            wb_log_q  <= RESET_BITS;
        end else begin
            rn_act_q  <= rn_act_d;
            archi_x_q <= archi_x_d;
            rn_buf_q  <= rn_buf_d;
            wb_log_q  <= wb_log_d;
        end
    end

    assign rnAct_X_qout = rn_act_q;
    assign archi_X_qout = archi_x_q;
    assign rnBufU_qout  = rn_buf_q;
    assign wbLog_qout   = wb_log_q;

endmodule

// File: tb/tb_phy_reg_state.sv
// Randomized bench for phy_reg_state against an array-based model of the
// rename maps and per-register copy bitmaps.
module tb_phy_reg_state;

    localparam int RB = 2;
    localparam int RP = 4;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic [RB*32-1:0]  rnAct_X_dnxt;
    logic [RB*32-1:0]  rnAct_X_qout;
    logic [32*RP-1:0]  rnBufU_rename_set;
    logic [32*RP-1:0]  rnBufU_qout;
    logic [32*RP-1:0]  wbLog_writeb_set;
    logic [32*RP-1:0]  wbLog_qout;
    logic [RB*32-1:0]  archi_X_qout;
    logic              commit_vaild;
    logic [5+RB-1:0]   commit_rd;
    logic              commit_abort;

    int checks = 0;
    int errors = 0;

    // model state
    int             m_act[32];
    int             m_arch[32];
    logic [RP-1:0]  m_busy[32];
    logic [RP-1:0]  m_wb[32];

    phy_reg_state #(.RB(RB), .RP(RP)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .rnAct_X_dnxt(rnAct_X_dnxt), .rnAct_X_qout(rnAct_X_qout),
        .rnBufU_rename_set(rnBufU_rename_set), .rnBufU_qout(rnBufU_qout),
        .wbLog_writeb_set(wbLog_writeb_set), .wbLog_qout(wbLog_qout),
        .archi_X_qout(archi_X_qout),
        .commit_vaild(commit_vaild), .commit_rd(commit_rd), .commit_abort(commit_abort)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_map(input int m[32]);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[RB*i +: RB] = m[i][RB-1:0];
        return v;
    endfunction

    function automatic logic [127:0] pack_bits(input logic [RP-1:0] b[32]);
        logic [127:0] v;
        for (int i = 0; i < 32; i++) v[RP*i +: RP] = b[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_act[i] = 0;
            m_arch[i] = 0;
            m_busy[i] = 4'b0001;
            m_wb[i] = 4'b0001;
        end
    endtask

    task automatic model_update();
        logic [RP-1:0] fr[32];
        logic [RP-1:0] set;
        int r, k;
        if (commit_abort) begin
            for (int i = 0; i < 32; i++) begin
                m_act[i] = m_arch[i];
                m_busy[i] = '0;
                m_busy[i][m_arch[i]] = 1'b1;
                m_wb[i] = m_busy[i];
            end
        end else begin
            for (int i = 0; i < 32; i++) fr[i] = '0;
            if (commit_vaild) begin
                r = int'(commit_rd[5+RB-1:RB]);
                k = int'(commit_rd[RB-1:0]);
                assert (m_busy[r][k]) else $error("commit of unallocated copy x%0d.%0d", r, k);
                if (m_arch[r] != k) fr[r][m_arch[r]] = 1'b1;
                m_arch[r] = k;
            end
            for (int i = 0; i < 32; i++) begin
                set = rnBufU_rename_set[RP*i +: RP];
                assert ((fr[i] & set) == 0) else $error("free and allocate of same copy x%0d", i);
                m_busy[i] = (m_busy[i] & ~fr[i]) | set;
                m_wb[i] = (m_wb[i] & ~fr[i] & ~set) | wbLog_writeb_set[RP*i +: RP];
                m_act[i] = int'(rnAct_X_dnxt[RB*i +: RB]);
            end
        end
    endtask

    task automatic compare_all();
        logic inv_ok;
        check("rnAct", {64'd0, rnAct_X_qout}, {64'd0, pack_map(m_act)});
        check("archi", {64'd0, archi_X_qout}, {64'd0, pack_map(m_arch)});
        check("rnBufU", rnBufU_qout, pack_bits(m_busy));
        check("wbLog", wbLog_qout, pack_bits(m_wb));
        inv_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (!rnBufU_qout[RP*i + int'(archi_X_qout[RB*i +: RB])]) inv_ok = 1'b0;
            if (!rnBufU_qout[RP*i + int'(rnAct_X_qout[RB*i +: RB])]) inv_ok = 1'b0;
        end
        if ((wbLog_qout & ~rnBufU_qout) != '0) inv_ok = 1'b0;
        check("invariants", inv_ok, 1'b1);
    endtask

    task automatic drive_idle();
        rnAct_X_dnxt = pack_map(m_act);
        rnBufU_rename_set = '0;
        wbLog_writeb_set = '0;
        commit_vaild = 1'b0;
        commit_rd = '0;
        commit_abort = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic rand_cycle();
        int n, c, r, k, freed;
        int cand[4];
        drive_idle();
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = 0;
                for (int j = 0; j < RP; j++) if (!m_busy[i][j]) begin cand[n] = j; n++; end
                if (n > 0) begin
                    c = cand[$urandom_range(0, n - 1)];
                    rnBufU_rename_set[RP*i + c] = 1'b1;
                    rnAct_X_dnxt[RB*i +: RB] = c[RB-1:0];
                end
            end
        end
        freed = -1;
        if ($urandom_range(0, 1) == 1) begin
            r = $urandom_range(0, 31);
            k = ($urandom_range(0, 1) == 1) ? m_act[r] : $urandom_range(0, RP - 1);
            // keep the copy the speculative map will point at alive
            if (m_busy[r][k] && (m_arch[r] == k || m_arch[r] != int'(rnAct_X_dnxt[RB*r +: RB]))) begin
                commit_vaild = 1'b1;
                commit_rd = {r[4:0], k[RB-1:0]};
                if (m_arch[r] != k) freed = RP*r + m_arch[r];
            end
        end
        for (int b = 0; b < 32*RP; b++) begin
            if ((m_busy[b/RP][b%RP] || rnBufU_rename_set[b]) && b != freed && $urandom_range(0, 3) == 0)
                wbLog_writeb_set[b] = 1'b1;
        end
        commit_abort = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        model_reset();
        RSTn = 1'b0;
        drive_idle();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        check("reset_rnAct", {64'd0, rnAct_X_qout}, 128'd0);
        check("reset_archi", {64'd0, archi_X_qout}, 128'd0);
        check("reset_rnBufU", rnBufU_qout, 128'h11111111_11111111_11111111_11111111);
        check("reset_wbLog", wbLog_qout, 128'h11111111_11111111_11111111_11111111);
        compare_all();

        // rename x5 -> copy 1, write it back, commit it
        drive_idle();
        rnAct_X_dnxt[10 +: 2] = 2'd1;
        rnBufU_rename_set[21] = 1'b1;
        step();
        check("x5_ren_buf", rnBufU_qout[20 +: 4], 4'h3);
        check("x5_ren_wb21", wbLog_qout[21], 1'b0);
        drive_idle();
        wbLog_writeb_set[21] = 1'b1;
        step();
        check("x5_wb21", wbLog_qout[21], 1'b1);
        drive_idle();
        commit_vaild = 1'b1;
        commit_rd = {5'd5, 2'd1};
        step();
        check("x5_commit_arch", archi_X_qout[10 +: 2], 2'd1);
        check("x5_commit_buf", rnBufU_qout[20 +: 4], 4'h2);
        check("x5_commit_wb", wbLog_qout[20 +: 4], 4'h2);

        // x7 copies 1..3 allocated, then flushed
        for (int c = 1; c < 4; c++) begin
            drive_idle();
            rnAct_X_dnxt[14 +: 2] = c[1:0];
            rnBufU_rename_set[28 + c] = 1'b1;
            step();
        end
        check("x7_alloc_buf", rnBufU_qout[28 +: 4], 4'hF);
        drive_idle();
        commit_abort = 1'b1;
        step();
        check("x7_flush_act", rnAct_X_qout[14 +: 2], 2'd0);
        check("x7_flush_buf", rnBufU_qout[28 +: 4], 4'h1);
        check("x7_flush_wb", wbLog_qout[28 +: 4], 4'h1);

        // commit together with abort: commit is dropped
        drive_idle();
        commit_vaild = 1'b1;
        commit_rd = {5'd3, 2'd2};
        commit_abort = 1'b1;
        rnAct_X_dnxt[6 +: 2] = 2'd2;
        rnBufU_rename_set[14] = 1'b1;
        wbLog_writeb_set[14] = 1'b1;
        step();
        check("abort_arch3", archi_X_qout[6 +: 2], 2'd0);
        check("abort_buf3", rnBufU_qout[12 +: 4], 4'h1);
        check("abort_act_eq_arch", {64'd0, rnAct_X_qout}, {64'd0, archi_X_qout});

        // commit x4.1 freeing copy 0 while renaming x4 -> 2 and writing x9.1
        drive_idle();
        rnAct_X_dnxt[8 +: 2] = 2'd1;
        rnBufU_rename_set[17] = 1'b1;
        rnAct_X_dnxt[18 +: 2] = 2'd1;
        rnBufU_rename_set[37] = 1'b1;
        step();
        drive_idle();
        commit_vaild = 1'b1;
        commit_rd = {5'd4, 2'd1};
        rnAct_X_dnxt[8 +: 2] = 2'd2;
        rnBufU_rename_set[18] = 1'b1;
        wbLog_writeb_set[37] = 1'b1;
        step();
        check("x4_buf", rnBufU_qout[16 +: 4], 4'h6);
        check("x4_wb", wbLog_qout[16 +: 4], 4'h0);
        check("x9_wb37", wbLog_qout[37], 1'b1);

        for (int n = 0; n < 400; n++) begin
            rand_cycle();
            step();
        end

        // asynchronous reset between edges
        step();
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        check("async_rst_buf", rnBufU_qout, 128'h11111111_11111111_11111111_11111111);
        check("async_rst_act", {64'd0, rnAct_X_qout}, 128'd0);
        compare_all();
        #1;
        RSTn = 1'b1;
        drive_idle();

        for (int n = 0; n < 200; n++) begin
            rand_cycle();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
